// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: shift mode encoding.
package shift_pkg;

  localparam int unsigned SHIFT_MODE_W = 2;

  typedef enum logic [SHIFT_MODE_W-1:0] {
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROR
  } shift_mode_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditional shift by 2^K plus its pipeline register.
// Rotate datapath only exists when BARREL_SHIFTER_ROTATE_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned K  = 0,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  shift_mode_t   in_mode,
  input  logic          in_lost,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic [SW-1:0] out_amt,
  output shift_mode_t   out_mode,
  output logic          out_lost
);

  localparam int unsigned S = 32'(1) << K;

  logic [N-1:0] shifted;
  logic         lost_c;

  // Shift selected by amt[K]; the sign bit stays in the MSB, so ASR fills from in_data[N-1].
  always_comb begin
    shifted = in_data;
    lost_c  = 1'b0;
    if (in_amt[K]) begin
      case (in_mode)
        SH_LSL: begin
          shifted = in_data << S;
          lost_c  = |in_data[N-1 -: S];
        end
        SH_ASR: begin
          shifted = {{S{in_data[N-1]}}, in_data[N-1:S]};
          lost_c  = |in_data[S-1:0];
        end
`ifdef BARREL_SHIFTER_ROTATE_EN
        SH_ROR: begin
          shifted = {in_data[S-1:0], in_data[N-1:S]};
          lost_c  = 1'b0;
        end
`endif
        default: begin
          shifted = in_data >> S;
          lost_c  = |in_data[S-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= SH_LSL;
      out_lost  <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
      out_lost  <= in_lost | lost_c;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter (LSL/LSR/ASR/ROR) with valid/ready backpressure.
// Define BARREL_SHIFTER_ROTATE_EN to build the rotate path; otherwise mode 11 acts as LSR.
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [N-1:0]            up_data,
  input  logic [SW-1:0]           up_amt,
  input  logic [SHIFT_MODE_W-1:0] up_mode,
  output logic                    down_valid,
  input  logic                    down_ready,
  output logic [N-1:0]            down_data,
  output logic                    down_lost
);

  logic          adv;
  logic          valid_q [SW+1];
  logic [N-1:0]  data_q  [SW+1];
  logic [SW-1:0] amt_q   [SW+1];
  shift_mode_t   mode_q  [SW+1];
  logic          lost_q  [SW+1];

  // Whole pipeline moves together whenever the output slot is free or being drained.
  assign adv      = down_ready | ~down_valid;
  assign up_ready = adv;

  assign valid_q[0] = up_valid & up_ready;
  assign data_q[0]  = up_data;
  assign amt_q[0]   = up_amt;
  assign mode_q[0]  = shift_mode_t'(up_mode);
  assign lost_q[0]  = 1'b0;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .N  (N),
      .K  (k),
      .SW (SW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (valid_q[k]),
      .in_data   (data_q[k]),
      .in_amt    (amt_q[k]),
      .in_mode   (mode_q[k]),
      .in_lost   (lost_q[k]),
      .out_valid (valid_q[k+1]),
      .out_data  (data_q[k+1]),
      .out_amt   (amt_q[k+1]),
      .out_mode  (mode_q[k+1]),
      .out_lost  (lost_q[k+1])
    );
  end

  assign down_valid = valid_q[SW];
  assign down_data  = data_q[SW];
  assign down_lost  = lost_q[SW];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=8): directed vectors, stream, stall, reset.
module tb_pipelined_barrel_shifter;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned L  = SW;

  logic          clk;
  logic          rst_n;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_amt;
  logic [1:0]    up_mode;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          down_lost;

  typedef struct packed {
    logic [N-1:0] d;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   n_in;
  int   n_out;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amt     (up_amt),
    .up_mode    (up_mode),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_lost  (down_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-amount reference, independent of the staged structure.
  function automatic exp_t ref_shift(input logic [N-1:0] a, input logic [SW-1:0] amt,
                                     input logic [1:0] mode);
    exp_t         r;
    logic [15:0]  wide;
    logic [N-1:0] mask;
    wide = {8'h00, a} << amt;
    mask = 8'((16'h1 << amt) - 16'h1);
    case (mode)
      2'b00: begin r.d = wide[7:0]; r.l = |wide[15:8]; end
      2'b10: begin r.d = 8'($signed(a) >>> amt); r.l = |(a & mask); end
`ifdef BARREL_SHIFTER_ROTATE_EN
      2'b11: begin r.d = 8'((a >> amt) | (a << (4'd8 - 4'(amt)))); r.l = 1'b0; end
`endif
      default: begin r.d = a >> amt; r.l = |(a & mask); end
    endcase
    return r;
  endfunction

  // One input presented alone; checks it emerges exactly L edges later, not earlier.
  task automatic send_check(input string tag, input logic [N-1:0] a, input logic [SW-1:0] amt,
                            input logic [1:0] mode, input logic [N-1:0] exp_d, input logic exp_l);
    up_valid = 1'b1; up_data = a; up_amt = amt; up_mode = mode; down_ready = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    repeat (L - 2) @(negedge clk);
    check({tag, "_early"}, down_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, down_valid, 1'b1);
    check({tag, "_data"}, down_data, exp_d);
    check({tag, "_lost"}, down_lost, exp_l);
    @(negedge clk);
  endtask

  // One clock of scoreboard-driven traffic; called right after a falling edge.
  task automatic cycle(input logic v, input logic [N-1:0] a, input logic [SW-1:0] amt,
                       input logic [1:0] mode, input logic rdy);
    exp_t e;
    up_valid = v; up_data = a; up_amt = amt; up_mode = mode; down_ready = rdy;
    #1;
    check("up_ready", up_ready, !down_valid || rdy);
    if (down_valid && rdy) begin
      check("scb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stream_data", down_data, e.d);
        check("stream_lost", down_lost, e.l);
      end
      n_out++;
    end
    if (v && up_ready) begin
      exp_q.push_back(ref_shift(a, amt, mode));
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 2'b00, 1'b1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_in_eq_out"}, n_out, n_in);
  endtask

  initial begin
    logic [N-1:0] hd;
    logic         hl;
    int           out0;
    checks = 0; errors = 0; n_in = 0; n_out = 0;
    rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_amt = '0; up_mode = '0; down_ready = 1'b0;
    #1;
    check("rst_down_valid", down_valid, 1'b0);
    check("rst_down_data", down_data, 8'h00);
    check("rst_down_lost", down_lost, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    down_ready = 1'b1;
    #1;
    check("rst_up_ready", up_ready, 1'b1);
    @(negedge clk);

    send_check("lsl3", 8'b1001_0110, 3'd3, 2'b00, 8'b1011_0000, 1'b1);
    send_check("lsr3", 8'b1001_0110, 3'd3, 2'b01, 8'b0001_0010, 1'b1);
    send_check("asr3", 8'b1001_0110, 3'd3, 2'b10, 8'b1111_0010, 1'b1);
`ifdef BARREL_SHIFTER_ROTATE_EN
    send_check("ror3", 8'b1001_0110, 3'd3, 2'b11, 8'b1101_0010, 1'b0);
`else
    send_check("ror3", 8'b1001_0110, 3'd3, 2'b11, 8'b0001_0010, 1'b1);
`endif
    send_check("amt0_lsl", 8'hA5, 3'd0, 2'b00, 8'hA5, 1'b0);
    send_check("amt0_lsr", 8'hA5, 3'd0, 2'b01, 8'hA5, 1'b0);
    send_check("amt0_asr", 8'hA5, 3'd0, 2'b10, 8'hA5, 1'b0);
    send_check("amt0_ror", 8'hA5, 3'd0, 2'b11, 8'hA5, 1'b0);
    send_check("lsl7", 8'h01, 3'd7, 2'b00, 8'h80, 1'b0);
    send_check("asr7_pos", 8'h7F, 3'd7, 2'b10, 8'h00, 1'b1);
    send_check("lsr5", 8'hE0, 3'd5, 2'b01, 8'h07, 1'b0);

    // Back-to-back random stream.
    out0 = n_out;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1);
    drain("stream");
    check("stream_count", n_out - out0, 20);

    // Fill, stall for 5 cycles, then drain.
    cycle(1'b1, 8'hC3, 3'd1, 2'b00, 1'b1);
    cycle(1'b1, 8'h81, 3'd2, 2'b10, 1'b1);
    cycle(1'b1, 8'h3C, 3'd4, 2'b01, 1'b1);
    cycle(1'b1, 8'h96, 3'd6, 2'b11, 1'b1);
    check("stall_full_valid", down_valid, 1'b1);
    hd = down_data;
    hl = down_lost;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'hFF, 3'd7, 2'b00, 1'b0);
      check("stall_valid", down_valid, 1'b1);
      check("stall_data", down_data, hd);
      check("stall_lost", down_lost, hl);
    end
    drain("stall");

    // Async reset with items in flight.
    cycle(1'b1, 8'h11, 3'd1, 2'b00, 1'b1);
    cycle(1'b1, 8'h22, 3'd2, 2'b01, 1'b1);
    cycle(1'b1, 8'h44, 3'd3, 2'b10, 1'b1);
    up_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", down_valid, 1'b0);
    check("midrst_data", down_data, 8'h00);
    check("midrst_lost", down_lost, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", down_valid, 1'b0);
    end
    send_check("post_rst", 8'h5A, 3'd2, 2'b00, 8'h68, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
